// File: rtl/gnw_pkg.sv
// Shared definitions for the gnw_core SDRAM image path: address and word
// widths, the download state encoding and the word-to-byte address helper.
package gnw_pkg;

    localparam int SDRAM_AW = 25;
    localparam int WORD_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Word index to even byte address, offset by base, wrapping modulo 2^25.
    function automatic logic [SDRAM_AW-1:0] word_byte_addr(
        input logic [SDRAM_AW-1:0] base,
        input logic [SDRAM_AW-2:0] word
    );
        return base + {word, 1'b0};
    endfunction

endpackage

// File: rtl/ioctl_sdram_writer_if.sv
// Bundle of the ioctl download stream and the SDRAM single-word write port.
// The writer is the slave modport; the host/controller side is the master.
interface ioctl_sdram_writer_if;
    import gnw_pkg::*;

    logic                ioctl_download;
    logic                ioctl_wr;
    logic [SDRAM_AW-1:0] ioctl_addr;
    logic [7:0]          ioctl_dout;
    logic                ioctl_wait;

    logic                sdram_wr_req;
    logic [SDRAM_AW-1:0] sdram_wr_addr;
    logic [WORD_W-1:0]   sdram_wr_data;
    logic [1:0]          sdram_wr_be;
    logic                sdram_wr_ack;

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, sdram_wr_ack,
        output ioctl_wait, sdram_wr_req, sdram_wr_addr, sdram_wr_data, sdram_wr_be
    );

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, sdram_wr_ack,
        input  ioctl_wait, sdram_wr_req, sdram_wr_addr, sdram_wr_data, sdram_wr_be
    );

endinterface

// File: rtl/ioctl_sdram_writer.sv
// Packs the ioctl byte stream into 16-bit little-endian words and issues
// single-word SDRAM write requests, stalling the host through ioctl_wait.
module ioctl_sdram_writer
    import gnw_pkg::*;
#(
    parameter logic [SDRAM_AW-1:0] BASE = 25'h0000000
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    ioctl_sdram_writer_if.slave  bus,
    output logic                 done,
    output logic                 overrun,
    output logic [23:0]          words
);

    state_t state, state_next;
    logic   dl_q;

    logic [SDRAM_AW-2:0] asm_word, asm_word_n;
    logic [WORD_W-1:0]   asm_data, asm_data_n;
    logic [1:0]          asm_be, asm_be_n;
    logic                asm_valid, asm_valid_n;

    logic                slot_valid, slot_valid_n;
    logic [SDRAM_AW-1:0] slot_addr, slot_addr_n;
    logic [WORD_W-1:0]   slot_data, slot_data_n;
    logic [1:0]          slot_be, slot_be_n;

    logic                wait_q;
    logic                done_n;
    logic                overrun_n;
    logic [23:0]         words_n;

    logic                dl_rise;
    logic                dl_fall;
    logic                strobe;
    logic                ack;
    logic                flushing;

    logic [SDRAM_AW-2:0] new_word;
    logic [WORD_W-1:0]   base_data;
    logic [1:0]          base_be;
    logic [WORD_W-1:0]   merged_data;
    logic [1:0]          merged_be;

    assign dl_rise  = bus.ioctl_download & ~dl_q;
    assign dl_fall  = ~bus.ioctl_download & dl_q;
    assign strobe   = bus.ioctl_wr & bus.ioctl_download & (state == ST_LOAD);
    assign ack      = bus.sdram_wr_ack & slot_valid;
    assign flushing = (state == ST_FLUSH) | ((state == ST_LOAD) & dl_fall);

    always_comb begin
        state_next   = state;
        asm_word_n   = asm_word;
        asm_data_n   = asm_data;
        asm_be_n     = asm_be;
        asm_valid_n  = asm_valid;
        slot_valid_n = slot_valid;
        slot_addr_n  = slot_addr;
        slot_data_n  = slot_data;
        slot_be_n    = slot_be;
        done_n       = 1'b0;
        overrun_n    = overrun;
        words_n      = words;
        new_word     = bus.ioctl_addr[SDRAM_AW-1:1];
        base_data    = asm_valid ? asm_data : '0;
        base_be      = asm_valid ? asm_be : 2'b00;
        merged_data  = '0;
        merged_be    = 2'b00;

        if (ack) begin
            slot_valid_n = 1'b0;
            words_n      = words + 24'd1;
        end

        if (dl_rise) begin
            words_n     = '0;
            overrun_n   = 1'b0;
            asm_valid_n = 1'b0;
            asm_data_n  = '0;
            asm_be_n    = 2'b00;
        end

        case (state)
            ST_IDLE: begin
                if (dl_rise) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (dl_fall) begin
                    state_next = ST_FLUSH;
                end else if (strobe) begin
                    // A busy slot includes the acknowledge cycle: the host saw ioctl_wait high.
                    if (slot_valid) begin
                        overrun_n = 1'b1;
                    end else begin
                        if (asm_valid && (new_word != asm_word)) begin
                            slot_valid_n = 1'b1;
                            slot_addr_n  = word_byte_addr(BASE, asm_word);
                            slot_data_n  = asm_data;
                            slot_be_n    = asm_be;
                            base_data    = '0;
                            base_be      = 2'b00;
                        end
                        merged_data = base_data;
                        if (bus.ioctl_addr[0]) begin
                            merged_data[15:8] = bus.ioctl_dout;
                        end else begin
                            merged_data[7:0] = bus.ioctl_dout;
                        end
                        merged_be = base_be | (bus.ioctl_addr[0] ? 2'b10 : 2'b01);
                        if (merged_be == 2'b11) begin
                            slot_valid_n = 1'b1;
                            slot_addr_n  = word_byte_addr(BASE, new_word);
                            slot_data_n  = merged_data;
                            slot_be_n    = merged_be;
                            asm_valid_n  = 1'b0;
                            asm_data_n   = '0;
                            asm_be_n     = 2'b00;
                        end else begin
                            asm_valid_n = 1'b1;
                            asm_word_n  = new_word;
                            asm_data_n  = merged_data;
                            asm_be_n    = merged_be;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (done) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // The leftover partial word waits for a free slot; done follows its acknowledge.
        if (flushing) begin
            if (asm_valid && !slot_valid) begin
                slot_valid_n = 1'b1;
                slot_addr_n  = word_byte_addr(BASE, asm_word);
                slot_data_n  = asm_data;
                slot_be_n    = asm_be;
                asm_valid_n  = 1'b0;
                asm_data_n   = '0;
                asm_be_n     = 2'b00;
            end else if (!asm_valid && (!slot_valid || ack) && !done) begin
                done_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= ST_IDLE;
            dl_q       <= 1'b0;
            asm_word   <= '0;
            asm_data   <= '0;
            asm_be     <= 2'b00;
            asm_valid  <= 1'b0;
            slot_valid <= 1'b0;
            slot_addr  <= '0;
            slot_data  <= '0;
            slot_be    <= 2'b00;
            wait_q     <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
            words      <= '0;
        end else begin
            state      <= state_next;
            dl_q       <= bus.ioctl_download;
            asm_word   <= asm_word_n;
            asm_data   <= asm_data_n;
            asm_be     <= asm_be_n;
            asm_valid  <= asm_valid_n;
            slot_valid <= slot_valid_n;
            slot_addr  <= slot_addr_n;
            slot_data  <= slot_data_n;
            slot_be    <= slot_be_n;
            wait_q     <= slot_valid_n;
            done       <= done_n;
            overrun    <= overrun_n;
            words      <= words_n;
        end
    end

    assign bus.ioctl_wait    = wait_q;
    assign bus.sdram_wr_req  = slot_valid;
    assign bus.sdram_wr_addr = slot_addr;
    assign bus.sdram_wr_data = slot_data;
    assign bus.sdram_wr_be   = slot_be;

endmodule

// File: tb/tb_ioctl_sdram_writer.sv
// Self-checking bench: host and SDRAM responder driven from one thread, with a
// byte-grouping reference model feeding a write scoreboard.
module tb_ioctl_sdram_writer;
    import gnw_pkg::*;

    localparam logic [24:0] TB_BASE = 25'h0123400;

    typedef struct packed {
        logic [24:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } wr_t;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        done;
    logic        overrun;
    logic [23:0] words;

    ioctl_sdram_writer_if bus();

    ioctl_sdram_writer #(.BASE(TB_BASE)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus),
        .done    (done),
        .overrun (overrun),
        .words   (words)
    );

    always #5 clk_sys = ~clk_sys;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    wr_t exp_q[$];
    wr_t seen_q[$];

    logic [23:0] m_word = '0;
    logic [15:0] m_data = '0;
    logic [1:0]  m_be = 2'b00;
    int          m_writes = 0;
    logic        overrun_exp = 1'b0;

    int   ack_delay = 1;
    int   ack_wait = 0;
    logic req_seen = 1'b0;
    wr_t  cur;
    int   last_ack_cyc = -1;
    int   done_cnt = 0;
    int   done_at = -1;
    int   wait_run = 0;
    int   last_wait_run = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic void push_write(input logic [23:0] w, input logic [15:0] d, input logic [1:0] be);
        wr_t r;
        r.addr = TB_BASE + {w, 1'b0};
        r.data = d;
        r.be   = be;
        exp_q.push_back(r);
        m_writes++;
    endfunction

    // Bytes of the same word gather until both lanes are present; a byte for a
    // different word sends the gathered partial word out first.
    function automatic bit model_byte(input logic [24:0] a, input logic [7:0] d);
        bit pushed = 1'b0;
        if (m_be != 2'b00 && a[24:1] != m_word) begin
            push_write(m_word, m_data, m_be);
            pushed = 1'b1;
            m_be   = 2'b00;
            m_data = '0;
        end
        m_word = a[24:1];
        if (a[0]) m_data[15:8] = d;
        else      m_data[7:0]  = d;
        m_be[a[0]] = 1'b1;
        if (m_be == 2'b11) begin
            push_write(m_word, m_data, m_be);
            pushed = 1'b1;
            m_be   = 2'b00;
            m_data = '0;
        end
        return pushed;
    endfunction

    task automatic run_cycle();
        logic ack_now;
        wr_t  obs;
        ack_now = 1'b0;
        if (done) begin
            done_cnt++;
            done_at = cyc;
        end
        if (bus.ioctl_wait) begin
            wait_run++;
        end else if (wait_run != 0) begin
            last_wait_run = wait_run;
            wait_run = 0;
        end
        if (bus.sdram_wr_req) begin
            obs.addr = bus.sdram_wr_addr;
            obs.data = bus.sdram_wr_data;
            obs.be   = bus.sdram_wr_be;
            if (!req_seen) begin
                req_seen = 1'b1;
                seen_q.push_back(obs);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_req", 64'(bus.sdram_wr_req), 64'(0));
                    cur = obs;
                end else begin
                    cur = exp_q.pop_front();
                    checkOutput("wr_addr", 64'(obs.addr), 64'(cur.addr));
                    checkOutput("wr_data", 64'(obs.data), 64'(cur.data));
                    checkOutput("wr_be", 64'(obs.be), 64'(cur.be));
                end
                ack_wait = ack_delay - 1;
            end else begin
                checkOutput("req_hold", 64'(obs), 64'(cur));
            end
            if (ack_wait == 0) ack_now = 1'b1;
            else ack_wait--;
        end
        bus.sdram_wr_ack = ack_now;
        @(posedge clk_sys);
        #1;
        if (ack_now) begin
            last_ack_cyc = cyc;
            req_seen = 1'b0;
        end
        cyc++;
        bus.sdram_wr_ack = 1'b0;
        bus.ioctl_wr = 1'b0;
        if (ack_now) checkOutput("req_after_ack", 64'(bus.sdram_wr_req), 64'(0));
    endtask

    task automatic applyStimulus(input logic [24:0] a, input logic [7:0] d, input bit force_strobe);
        int guard;
        bit pushed;
        guard = 0;
        pushed = 1'b0;
        if (!force_strobe) begin
            while (bus.ioctl_wait && guard < 200) begin
                run_cycle();
                guard++;
            end
            if (guard >= 200) checkOutput("wait_timeout", 64'(bus.ioctl_wait), 64'(0));
        end
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        if (force_strobe) overrun_exp = 1'b1;
        else pushed = model_byte(a, d);
        run_cycle();
        if (pushed) checkOutput("latency_req", 64'(bus.sdram_wr_req), 64'(1));
    endtask

    task automatic start_download();
        m_be = 2'b00;
        m_data = '0;
        m_writes = 0;
        overrun_exp = 1'b0;
        seen_q.delete();
        bus.ioctl_download = 1'b1;
        run_cycle();
        checkOutput("start_words", 64'(words), 64'(0));
        checkOutput("start_overrun", 64'(overrun), 64'(0));
        run_cycle();
    endtask

    task automatic end_download();
        int f;
        int guard;
        int exp_done;
        if (m_be != 2'b00) begin
            push_write(m_word, m_data, m_be);
            m_be = 2'b00;
            m_data = '0;
        end
        bus.ioctl_download = 1'b0;
        f = cyc;
        done_cnt = 0;
        done_at = -1;
        guard = 0;
        while ((exp_q.size() != 0 || req_seen || bus.sdram_wr_req || done_cnt == 0) && guard < 300) begin
            run_cycle();
            guard++;
        end
        run_cycle();
        run_cycle();
        exp_done = (last_ack_cyc >= f) ? last_ack_cyc + 1 : f + 1;
        checkOutput("flush_drain", 64'(exp_q.size()), 64'(0));
        checkOutput("done_cycle", 64'(done_at), 64'(exp_done));
        checkOutput("done_count", 64'(done_cnt), 64'(1));
        checkOutput("words", 64'(words), 64'(m_writes));
        checkOutput("overrun", 64'(overrun), 64'(overrun_exp));
    endtask

    initial begin
        wr_t         want;
        logic [7:0]  b [5];
        logic [24:0] a;
        int          n;

        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.sdram_wr_ack   = 1'b0;

        run_cycle();
        run_cycle();
        checkOutput("rst_req", 64'(bus.sdram_wr_req), 64'(0));
        checkOutput("rst_wait", 64'(bus.ioctl_wait), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));
        checkOutput("rst_overrun", 64'(overrun), 64'(0));
        checkOutput("rst_words", 64'(words), 64'(0));
        checkOutput("rst_bus", 64'({bus.sdram_wr_addr, bus.sdram_wr_data, bus.sdram_wr_be}), 64'(0));
        reset = 1'b0;
        run_cycle();

        // Two bytes of one word, immediate acknowledge.
        ack_delay = 1;
        start_download();
        applyStimulus(25'd0, 8'h11, 1'b0);
        applyStimulus(25'd1, 8'h22, 1'b0);
        run_cycle();
        run_cycle();
        want = '{addr: TB_BASE, data: 16'h2211, be: 2'b11};
        checkOutput("t1_count", 64'(seen_q.size()), 64'(1));
        if (seen_q.size() > 0) checkOutput("t1_write", 64'(seen_q[0]), 64'(want));
        checkOutput("t1_words", 64'(words), 64'(1));
        end_download();

        // Five bytes: two full words and a trailing partial.
        start_download();
        for (int i = 0; i < 5; i++) begin
            b[i] = 8'($urandom);
            applyStimulus(25'(i), b[i], 1'b0);
        end
        end_download();
        checkOutput("t2_count", 64'(seen_q.size()), 64'(3));
        want = '{addr: TB_BASE + 25'd4, data: {8'h00, b[4]}, be: 2'b01};
        if (seen_q.size() > 2) checkOutput("t2_partial", 64'(seen_q[2]), 64'(want));
        checkOutput("t2_words", 64'(words), 64'(3));

        // Non-contiguous bytes become two partial words.
        start_download();
        applyStimulus(25'h10, 8'hA5, 1'b0);
        applyStimulus(25'h21, 8'h5A, 1'b0);
        end_download();
        checkOutput("t3_count", 64'(seen_q.size()), 64'(2));
        want = '{addr: TB_BASE + 25'h10, data: 16'h00A5, be: 2'b01};
        if (seen_q.size() > 0) checkOutput("t3_first", 64'(seen_q[0]), 64'(want));
        want = '{addr: TB_BASE + 25'h20, data: 16'h5A00, be: 2'b10};
        if (seen_q.size() > 1) checkOutput("t3_second", 64'(seen_q[1]), 64'(want));

        // Address wrap of the BASE offset.
        start_download();
        applyStimulus(25'h1FFFFFE, 8'h01, 1'b0);
        applyStimulus(25'h1FFFFFF, 8'h02, 1'b0);
        end_download();
        want = '{addr: 25'h01233FE, data: 16'h0201, be: 2'b11};
        if (seen_q.size() > 0) checkOutput("wrap_write", 64'(seen_q[0]), 64'(want));

        // Seven-cycle acknowledge with a strobe forced into the wait window.
        ack_delay = 7;
        start_download();
        applyStimulus(25'h40, 8'h31, 1'b0);
        checkOutput("t4_overrun_pre", 64'(overrun), 64'(0));
        applyStimulus(25'h41, 8'h32, 1'b0);
        applyStimulus(25'h44, 8'hEE, 1'b1);
        n = 0;
        while (bus.ioctl_wait && n < 50) begin
            run_cycle();
            n++;
        end
        run_cycle();
        checkOutput("t4_wait_len", 64'(last_wait_run), 64'(7));
        checkOutput("t4_overrun", 64'(overrun), 64'(1));
        applyStimulus(25'h42, 8'h33, 1'b0);
        applyStimulus(25'h43, 8'h34, 1'b0);
        end_download();

        // Reset while a request is outstanding.
        ack_delay = 10;
        start_download();
        applyStimulus(25'h0, 8'h77, 1'b0);
        applyStimulus(25'h1, 8'h88, 1'b0);
        run_cycle();
        reset = 1'b1;
        done_cnt = 0;
        run_cycle();
        checkOutput("rstmid_req", 64'(bus.sdram_wr_req), 64'(0));
        checkOutput("rstmid_wait", 64'(bus.ioctl_wait), 64'(0));
        checkOutput("rstmid_done", 64'(done), 64'(0));
        reset = 1'b0;
        exp_q.delete();
        req_seen = 1'b0;
        bus.ioctl_download = 1'b0;
        for (int i = 0; i < 4; i++) run_cycle();
        checkOutput("rstmid_no_done", 64'(done_cnt), 64'(0));
        ack_delay = 2;
        start_download();
        applyStimulus(25'h6, 8'h12, 1'b0);
        applyStimulus(25'h7, 8'h34, 1'b0);
        end_download();
        checkOutput("rstmid_words", 64'(words), 64'(1));

        // Randomized downloads.
        for (int d = 0; d < 25; d++) begin
            n = $urandom_range(1, 24);
            if ($urandom_range(0, 1) == 1) a = 25'($urandom);
            else a = 25'($urandom_range(0, 63));
            ack_delay = $urandom_range(1, 4);
            start_download();
            for (int i = 0; i < n; i++) begin
                if (bus.ioctl_wait && $urandom_range(0, 9) == 0)
                    applyStimulus(a + 25'd7, 8'($urandom), 1'b1);
                applyStimulus(a, 8'($urandom), 1'b0);
                case ($urandom_range(0, 9))
                    0:       a = a + 25'($urandom_range(2, 9));
                    1:       a = a - 25'd1;
                    default: a = a + 25'd1;
                endcase
                if ($urandom_range(0, 3) == 0) run_cycle();
            end
            end_download();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
